// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage_pkg                                                    |
// | Brief   : Shared CPU definitions: FSM states, funct3 codes, store helpers  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage_if                                                     |
// | Brief   : Data-memory request/response bus between MEM stage and memory   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_ready_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_ready_i, dmem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_align                                                       |
// | Brief   : Selects and sign/zero-extends load data from the read word      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_align
    import mem_stage_pkg::*;
(
    input  wire logic [1:0]  i_addr,
    input  wire logic [2:0]  i_funct3,
    input  wire logic [31:0] i_rdata,
    output logic      [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        case (i_funct3)
            c_f3_b:  o_result = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: o_result = {24'd0, w_byte};
            c_f3_h:  o_result = {{16{w_half[15]}}, w_half};
            c_f3_hu: o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_stage                                                        |
// | Brief   : Pipeline MEM stage with stalling data-memory access and timeout |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        valid_i,
    input  wire logic        mem_rd_i,
    input  wire logic        mem_wr_i,
    input  wire logic [2:0]  funct3_i,
    input  wire logic [31:0] alu_result_i,
    input  wire logic [31:0] rs2_data_i,
    input  wire logic [31:0] pc4_i,
    input  wire logic [1:0]  wb_sel_i,
    input  wire logic [4:0]  rd_addr_i,
    input  wire logic        reg_we_i,
    mem_stage_if.master      dmem,
    output logic             wb_valid_o,
    output logic      [1:0]  wb_sel_o,
    output logic      [31:0] data_r_o,
    output logic      [31:0] alu_result_o,
    output logic      [31:0] pc4_o,
    output logic      [4:0]  rd_addr_o,
    output logic             reg_we_o,
    output logic             stall_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    localparam int                 c_cnt_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    // Pending access, captured on every IDLE cycle so WAIT can replay it
    logic        r_we, r_is_load, r_reg_we;
    logic [31:0] r_addr, r_wdata, r_pc4;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [1:0]  r_wb_sel;
    logic [4:0]  r_rd_addr;

    logic        w_idle, w_mem_op, w_misalign, w_issue, w_req, w_ready, w_timeout;
    logic [3:0]  w_be_new;
    logic [31:0] w_wdata_new, w_load_data;

    assign w_idle      = (r_state == c_st_idle);
    assign w_mem_op    = valid_i & (mem_rd_i | mem_wr_i);
    assign w_misalign  = w_mem_op & is_misaligned(funct3_i, alu_result_i[1:0]);
    assign w_issue     = w_idle & w_mem_op & ~w_misalign;
    // Request is forced low while reset is held, even with a valid op presented
    assign w_req       = rst_ni & (w_issue | ~w_idle);
    assign w_ready     = w_req & dmem.dmem_ready_i;
    assign w_timeout   = ~w_idle & ~dmem.dmem_ready_i & (r_cnt == c_cnt_last);
    assign stall_o     = w_req & ~w_ready & ~w_timeout;

    assign w_be_new    = mem_wr_i ? store_be(funct3_i, alu_result_i[1:0]) : 4'b1111;
    assign w_wdata_new = store_data(funct3_i, rs2_data_i);

    assign dmem.dmem_req_o   = w_req;
    assign dmem.dmem_we_o    = w_idle ? mem_wr_i : r_we;
    assign dmem.dmem_addr_o  = w_idle ? {alu_result_i[31:2], 2'b00} : {r_addr[31:2], 2'b00};
    assign dmem.dmem_wdata_o = w_idle ? w_wdata_new : r_wdata;
    assign dmem.dmem_be_o    = w_idle ? w_be_new : r_be;

    load_align u_load_align (
        .i_addr   (w_idle ? alu_result_i[1:0] : r_addr[1:0]),
        .i_funct3 (w_idle ? funct3_i : r_funct3),
        .i_rdata  (dmem.dmem_rdata_i),
        .o_result (w_load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
            r_reg_we  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_pc4     <= '0;
            r_be      <= '0;
            r_funct3  <= '0;
            r_wb_sel  <= '0;
            r_rd_addr <= '0;
        end else if (w_idle) begin
            r_cnt     <= '0;
            r_we      <= mem_wr_i;
            r_is_load <= mem_rd_i & ~mem_wr_i;
            r_reg_we  <= reg_we_i;
            r_addr    <= alu_result_i;
            r_wdata   <= w_wdata_new;
            r_pc4     <= pc4_i;
            r_be      <= w_be_new;
            r_funct3  <= funct3_i;
            r_wb_sel  <= wb_sel_i;
            r_rd_addr <= rd_addr_i;
            if (w_issue && !w_ready) begin
                r_state <= c_st_wait;
            end
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_ready || w_timeout) begin
                r_state <= c_st_idle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o   <= 1'b0;
            wb_sel_o     <= '0;
            data_r_o     <= '0;
            alu_result_o <= '0;
            pc4_o        <= '0;
            rd_addr_o    <= '0;
            reg_we_o     <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (w_idle) begin
                wb_sel_o     <= wb_sel_i;
                alu_result_o <= alu_result_i;
                pc4_o        <= pc4_i;
                rd_addr_o    <= rd_addr_i;
                if (!valid_i || (w_issue && !w_ready)) begin
                    wb_valid_o <= 1'b0;
                    reg_we_o   <= 1'b0;
                end else if (w_misalign) begin
                    wb_valid_o <= 1'b1;
                    reg_we_o   <= 1'b0;
                    data_r_o   <= '0;
                    misalign_o <= 1'b1;
                end else begin
                    wb_valid_o <= 1'b1;
                    reg_we_o   <= reg_we_i;
                    data_r_o   <= (w_issue && mem_rd_i && !mem_wr_i) ? w_load_data : 32'd0;
                end
            end else if (w_ready || w_timeout) begin
                wb_valid_o   <= 1'b1;
                wb_sel_o     <= r_wb_sel;
                alu_result_o <= r_addr;
                pc4_o        <= r_pc4;
                rd_addr_o    <= r_rd_addr;
                reg_we_o     <= w_ready & r_reg_we;
                data_r_o     <= (w_ready && r_is_load) ? w_load_data : 32'd0;
                bus_err_o    <= w_timeout;
            end else begin
                wb_valid_o <= 1'b0;
                reg_we_o   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_stage                                                     |
// | Brief   : Self-checking bench for mem_stage against a behavioural model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        valid, mem_rd, mem_wr, reg_we;
    logic [2:0]  funct3;
    logic [31:0] alu, rs2, pc4;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_addr;
    logic        wb_valid, wb_reg_we, stall, misalign, bus_err;
    logic [1:0]  wb_sel_q;
    logic [31:0] data_r, alu_q, pc4_q;
    logic [4:0]  rd_q;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .funct3_i(funct3), .alu_result_i(alu), .rs2_data_i(rs2), .pc4_i(pc4), .wb_sel_i(wb_sel),
        .rd_addr_i(rd_addr), .reg_we_i(reg_we), .dmem(dmem_bus),
        .wb_valid_o(wb_valid), .wb_sel_o(wb_sel_q), .data_r_o(data_r), .alu_result_o(alu_q),
        .pc4_o(pc4_q), .rd_addr_o(rd_q), .reg_we_o(wb_reg_we), .stall_o(stall),
        .misalign_o(misalign), .bus_err_o(bus_err)
    );

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_access
    int          obs_stall, obs_req;
    logic        obs_unstable, obs_hung, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        s_valid, s_we, s_mis, s_berr, a_valid, a_mis, a_berr;
    logic [31:0] s_data, s_alu, s_pc4;
    logic [1:0]  s_sel;
    logic [4:0]  s_rd;

    // Model expectations
    int          e_stall, e_req;
    logic        e_valid, e_we, e_mis, e_berr;
    logic [31:0] e_data, e_addr, e_wdata;
    logic [3:0]  e_be;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> ((a % 4) * 8)) % 256;
        h = (rdata >> (((a % 4) >= 2) ? 16 : 0)) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic void model(input logic v, r, w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, input logic we, input int delay,
                                  input logic [31:0] rdata);
        int  size, waits;
        logic mem, mis, err;
        size = f3 % 4;
        mem  = v && (r || w);
        mis  = mem && ((size == 1 && (a % 2) != 0) || (size >= 2 && (a % 4) != 0));
        err  = (delay < 0) || (delay > TIMEOUT);
        waits = err ? TIMEOUT : delay;
        e_mis = mis; e_berr = 0; e_stall = 0; e_req = 0; e_data = 0;
        e_addr = a - (a % 4);
        e_be   = (size == 0) ? 4'(1 << (a % 4)) : (size == 1) ? (((a % 4) >= 2) ? 4'hC : 4'h3) : 4'hF;
        e_wdata = (size == 0) ? (d % 256) * 32'h0101_0101 : (size == 1) ? (d % 65536) * 32'h0001_0001 : d;
        if (!v) begin
            e_valid = 0; e_we = 0;
        end else if (!mem) begin
            e_valid = 1; e_we = we;
        end else if (mis) begin
            e_valid = 1; e_we = 0;
        end else begin
            e_valid = 1; e_stall = waits; e_req = waits + 1; e_berr = err;
            e_we   = err ? 1'b0 : we;
            e_data = (err || w) ? 32'd0 : ref_load(f3, a, rdata);
        end
    endfunction

    // Drives one instruction; inputs are scrambled while the stage is stalled.
    // delay: cycle index (0 = same cycle) at which ready is raised, negative = never.
    task automatic run_access(input logic v, r, w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, p, input logic [1:0] sel,
                              input logic [4:0] rd, input logic we, input int delay,
                              input logic [31:0] rdata);
        logic stalled, done;
        obs_stall = 0; obs_req = 0; obs_unstable = 0; done = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                valid = v; mem_rd = r; mem_wr = w; funct3 = f3; alu = a; rs2 = d;
                pc4 = p; wb_sel = sel; rd_addr = rd; reg_we = we;
            end else begin
                valid = 1'($urandom); mem_rd = 1'($urandom); mem_wr = 1'($urandom);
                funct3 = 3'($urandom); alu = $urandom; rs2 = $urandom; pc4 = $urandom;
                wb_sel = 2'($urandom); rd_addr = 5'($urandom); reg_we = 1'($urandom);
            end
            dmem_bus.dmem_ready_i = (delay == k);
            dmem_bus.dmem_rdata_i = (delay == k) ? rdata : $urandom;
            #1;
            if (dmem_bus.dmem_req_o) begin
                obs_req++;
                if (obs_req == 1) begin
                    obs_addr = dmem_bus.dmem_addr_o; obs_we = dmem_bus.dmem_we_o;
                    obs_be = dmem_bus.dmem_be_o; obs_wdata = dmem_bus.dmem_wdata_o;
                end else if (obs_addr !== dmem_bus.dmem_addr_o || obs_we !== dmem_bus.dmem_we_o ||
                             obs_be !== dmem_bus.dmem_be_o || obs_wdata !== dmem_bus.dmem_wdata_o) begin
                    obs_unstable = 1;
                end
            end
            stalled = stall;
            if (stalled) obs_stall++;
            @(posedge clk); #1;
            if (!stalled) begin done = 1; break; end
        end
        obs_hung = !done;
        s_valid = wb_valid; s_we = wb_reg_we; s_mis = misalign; s_berr = bus_err;
        s_data = data_r; s_alu = alu_q; s_pc4 = pc4_q; s_sel = wb_sel_q; s_rd = rd_q;
        @(negedge clk);
        valid = 0; dmem_bus.dmem_ready_i = 0;
        @(posedge clk); #1;
        a_valid = wb_valid; a_mis = misalign; a_berr = bus_err;
    endtask

    task automatic test_reset();
        valid = 1; mem_rd = 1; mem_wr = 0; funct3 = c_f3_w; alu = 32'h100;
        dmem_bus.dmem_ready_i = 1; dmem_bus.dmem_rdata_i = 32'h1234_5678;
        #2 rst_n = 0;
        #1;
        total++;
        if (dmem_bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_comb req=%b stall=%b expected 0 0", dmem_bus.dmem_req_o, stall);
        end
        @(posedge clk); #1;
        total++;
        if ({wb_valid, wb_sel_q, data_r, alu_q, pc4_q, rd_q, wb_reg_we, misalign, bus_err} !== '0) begin
            bad++; $display("FAIL reset_regs wb_valid=%b data=%h alu=%h pc4=%h we=%b expected all 0",
                            wb_valid, data_r, alu_q, pc4_q, wb_reg_we);
        end
        @(negedge clk);
        valid = 0; dmem_bus.dmem_ready_i = 0; rst_n = 1;
    endtask

    task automatic test_lw_same_cycle();
        run_access(1, 1, 0, c_f3_w, 32'h100, 32'h0, 32'h44, 2'd1, 5'd7, 1, 0, 32'hDEAD_BEEF);
        total++;
        if (obs_stall != 0 || obs_req != 1) begin
            bad++; $display("FAIL lw_nostall stall=%0d req=%0d expected 0 1", obs_stall, obs_req);
        end
        total++;
        if ({s_valid, s_we, s_data, s_rd} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 5'd7}) begin
            bad++; $display("FAIL lw_wb valid=%b we=%b data=%h rd=%0d expected 1 1 deadbeef 7",
                            s_valid, s_we, s_data, s_rd);
        end
    endtask

    task automatic test_lb_wait();
        run_access(1, 1, 0, c_f3_b, 32'h103, 32'h0, 32'h48, 2'd1, 5'd3, 1, 3, 32'h80FF_FF7F);
        total++;
        if (obs_stall != 3 || obs_unstable || obs_addr !== 32'h100) begin
            bad++; $display("FAIL lb_wait stall=%0d unstable=%b addr=%h expected 3 0 00000100",
                            obs_stall, obs_unstable, obs_addr);
        end
        total++;
        if (s_data !== 32'hFFFF_FF80 || s_valid !== 1'b1) begin
            bad++; $display("FAIL lb_data data=%h valid=%b expected ffffff80 1", s_data, s_valid);
        end
        run_access(1, 1, 0, c_f3_bu, 32'h103, 32'h0, 32'h4C, 2'd1, 5'd3, 1, 3, 32'h80FF_FF7F);
        total++;
        if (s_data !== 32'h0000_0080) begin
            bad++; $display("FAIL lbu_data data=%h expected 00000080", s_data);
        end
    endtask

    task automatic test_store_sh();
        run_access(1, 0, 1, c_f3_h, 32'h202, 32'h0000_ABCD, 32'h50, 2'd0, 5'd9, 1, 1, 32'h0);
        total++;
        if ({obs_be, obs_wdata, obs_addr, obs_we} !== {4'b1100, 32'hABCD_ABCD, 32'h200, 1'b1}) begin
            bad++; $display("FAIL sh_bus be=%b wdata=%h addr=%h we=%b expected 1100 abcdabcd 00000200 1",
                            obs_be, obs_wdata, obs_addr, obs_we);
        end
        total++;
        if (s_data !== 32'h0 || s_we !== 1'b1 || obs_unstable) begin
            bad++; $display("FAIL sh_wb data=%h we=%b unstable=%b expected 0 1 0", s_data, s_we, obs_unstable);
        end
    endtask

    task automatic test_misalign();
        run_access(1, 1, 0, c_f3_w, 32'h101, 32'h0, 32'h54, 2'd1, 5'd4, 1, 0, 32'hCAFE_F00D);
        total++;
        if (obs_req != 0 || obs_stall != 0) begin
            bad++; $display("FAIL mis_req req_cycles=%0d stall=%0d expected 0 0", obs_req, obs_stall);
        end
        total++;
        if ({s_mis, a_mis, s_we, s_valid} !== 4'b1001) begin
            bad++; $display("FAIL mis_pulse mis=%b next=%b we=%b valid=%b expected 1 0 0 1",
                            s_mis, a_mis, s_we, s_valid);
        end
    endtask

    task automatic test_timeout();
        run_access(1, 1, 0, c_f3_w, 32'h300, 32'h0, 32'h58, 2'd1, 5'd5, 1, -1, 32'h0);
        total++;
        if (obs_stall != TIMEOUT || obs_hung) begin
            bad++; $display("FAIL tmo_stall stall=%0d hung=%b expected %0d 0", obs_stall, obs_hung, TIMEOUT);
        end
        total++;
        if ({s_berr, a_berr, s_we, s_valid} !== 4'b1001 || s_data !== 32'h0) begin
            bad++; $display("FAIL tmo_err berr=%b next=%b we=%b valid=%b data=%h expected 1 0 0 1 0",
                            s_berr, a_berr, s_we, s_valid, s_data);
        end
        run_access(1, 0, 0, c_f3_w, 32'h77, 32'h0, 32'h5C, 2'd0, 5'd6, 1, 0, 32'h0);
        total++;
        if (obs_stall != 0 || s_valid !== 1'b1 || s_alu !== 32'h77) begin
            bad++; $display("FAIL tmo_idle stall=%0d valid=%b alu=%h expected 0 1 00000077",
                            obs_stall, s_valid, s_alu);
        end
        run_access(1, 1, 0, c_f3_w, 32'h304, 32'h0, 32'h60, 2'd1, 5'd5, 1, TIMEOUT, 32'h1357_9BDF);
        total++;
        if (s_berr !== 1'b0 || s_data !== 32'h1357_9BDF || s_we !== 1'b1 || obs_stall != TIMEOUT) begin
            bad++; $display("FAIL tmo_ready_wins berr=%b data=%h we=%b stall=%0d expected 0 13579bdf 1 %0d",
                            s_berr, s_data, s_we, obs_stall, TIMEOUT);
        end
    endtask

    task automatic test_reset_in_wait();
        int hits;
        @(negedge clk);
        valid = 1; mem_rd = 1; mem_wr = 0; funct3 = c_f3_w; alu = 32'h104; pc4 = 32'h64;
        rd_addr = 5'd2; reg_we = 1; dmem_bus.dmem_ready_i = 0;
        @(posedge clk);
        @(negedge clk);
        valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({wb_valid, alu_q, pc4_q, stall, dmem_bus.dmem_req_o} !== '0) begin
            bad++; $display("FAIL rst_wait wb_valid=%b alu=%h pc4=%h stall=%b req=%b expected all 0",
                            wb_valid, alu_q, pc4_q, stall, dmem_bus.dmem_req_o);
        end
        @(negedge clk);
        rst_n = 1;
        hits = 0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            @(negedge clk);
            dmem_bus.dmem_ready_i = 1'($urandom); dmem_bus.dmem_rdata_i = $urandom;
            @(posedge clk); #1;
            if (wb_valid || bus_err || stall) hits++;
        end
        dmem_bus.dmem_ready_i = 0;
        total++;
        if (hits != 0) begin
            bad++; $display("FAIL rst_abandon late_events=%0d expected 0", hits);
        end
    endtask

    task automatic test_random();
        logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a, d, p, rdata;
        logic        v, r, w, we;
        logic [1:0]  sel;
        logic [4:0]  rd;
        int          kind, delay;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 7);
            v = (kind != 0); r = (kind >= 2 && kind <= 4); w = (kind >= 5);
            f3 = w ? ld_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
            a = 32'h1000 + $urandom_range(0, 63); d = $urandom; p = $urandom; rdata = $urandom;
            sel = 2'($urandom); rd = 5'($urandom); we = 1'($urandom);
            delay = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 10);
            model(v, r, w, f3, a, d, we, delay, rdata);
            run_access(v, r, w, f3, a, d, p, sel, rd, we, delay, rdata);
            total++;
            if (obs_stall != e_stall || obs_req != e_req || obs_hung || obs_unstable) begin
                bad++; $display("FAIL rnd%0d_flow stall=%0d req=%0d hung=%b unstable=%b expected %0d %0d 0 0",
                                it, obs_stall, obs_req, obs_hung, obs_unstable, e_stall, e_req);
            end
            total++;
            if ({s_valid, s_we, s_mis, s_berr, a_mis, a_berr, a_valid} !== {e_valid, e_we, e_mis, e_berr, 3'b000}) begin
                bad++; $display("FAIL rnd%0d_ctl valid/we/mis/berr=%b%b%b%b next=%b%b%b expected %b%b%b%b 000",
                                it, s_valid, s_we, s_mis, s_berr, a_mis, a_berr, a_valid,
                                e_valid, e_we, e_mis, e_berr);
            end
            if (e_valid) begin
                total++;
                if ({s_data, s_alu, s_pc4, s_sel, s_rd} !== {e_data, a, p, sel, rd}) begin
                    bad++; $display("FAIL rnd%0d_wb data=%h alu=%h pc4=%h sel=%0d rd=%0d expected %h %h %h %0d %0d",
                                    it, s_data, s_alu, s_pc4, s_sel, s_rd, e_data, a, p, sel, rd);
                end
            end
            if (e_req > 0) begin
                total++;
                if (obs_addr !== e_addr || obs_we !== w || (w && (obs_be !== e_be || obs_wdata !== e_wdata))) begin
                    bad++; $display("FAIL rnd%0d_bus addr=%h we=%b be=%b wdata=%h expected %h %b %b %h",
                                    it, obs_addr, obs_we, obs_be, obs_wdata, e_addr, w, e_be, e_wdata);
                end
            end
        end
    endtask

    initial begin
        valid = 0; mem_rd = 0; mem_wr = 0; funct3 = 0; alu = 0; rs2 = 0; pc4 = 0;
        wb_sel = 0; rd_addr = 0; reg_we = 0;
        dmem_bus.dmem_ready_i = 0; dmem_bus.dmem_rdata_i = 0;
        test_reset();
        test_lw_same_cycle();
        test_lb_wait();
        test_store_sh();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
